// File: rtl/bus_rr_arbiter_if.sv
// Bundle of per-agent FIFO handshake and data lanes seen by bus_rr_arbiter.
// The master modport is the arbiter side; the slave modport is the FIFO side.
interface bus_rr_arbiter_if #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0]              push;
    logic [drvrs-1:0][pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin shared-bus arbiter: pops one packet per 3 clocks from a pending agent and
// pushes it to its destination(s). Define BUS_BCAST_SELF_EN to include the source in broadcasts.
module bus_rr_arbiter #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    bus_rr_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    // The last-grant pointer doubles as the current grant while READ/WRITE are in flight.
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;

    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [7:0]           dest;

    // First pending agent strictly after the last grant, wrapping at drvrs.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= drvrs; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= drvrs) begin
                idx = idx - drvrs;
            end
            if (!found && bus.pndng[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pop_d   = '0;
        push_d  = '0;
        pkt_d   = pkt_q;
        dest    = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_d      = sel;
                    pop_d[sel] = 1'b1;
                    state_d    = READ;
                end
            end

            READ: begin
                // The grant is committed here regardless of pndng; the FWFT head word is taken as-is.
                pkt_d = bus.D_pop[ptr_q];
                dest  = pkt_d[pckg_sz-1 -: 8];
                if (int'(dest) < drvrs) begin
                    push_d[dest[IDX_W-1:0]] = 1'b1;
                end else if (dest == broadcast) begin
                    push_d = '1;
`ifdef BUS_BCAST_SELF_EN
`else
                    push_d[ptr_q] = 1'b0;
`endif
                end
                state_d = WRITE;
            end

            WRITE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(drvrs - 1);
            pop_q   <= '0;
            push_q  <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            pkt_q   <= pkt_d;
        end
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.D_push = {drvrs{pkt_q}};
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with 8 agents and 20-bit packets; inputs change and
// outputs are sampled on the falling edge.
module tb_bus_rr_arbiter;
    localparam int DRV = 8;
    localparam int PSZ = 20;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bus_rr_arbiter_if #(.drvrs(DRV), .pckg_sz(PSZ)) bus ();

    bus_rr_arbiter #(
        .drvrs    (DRV),
        .pckg_sz  (PSZ),
        .broadcast(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.pndng  = '0;
        bus.D_pop  = '0;
        repeat (2) tick();
        n_checks++;
        if (bus.pop !== 8'h00) begin n_fail++; $display("FAIL reset_pop: got %h want %h", bus.pop, 8'h00); end
        n_checks++;
        if (bus.push !== 8'h00) begin n_fail++; $display("FAIL reset_push: got %h want %h", bus.push, 8'h00); end
        n_checks++;
        if (bus.D_push !== '0) begin n_fail++; $display("FAIL reset_dpush: got %h want 0", bus.D_push); end
        reset = 1'b1;
        tick();
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL reset_idle: pop %h push %h want 00", bus.pop, bus.push); end
    endtask

    task automatic test_unicast();
        bus.D_pop[1] = 20'h02ABC;
        bus.pndng    = 8'h02;
        tick();
        n_checks++;
        if (bus.pop !== 8'h02 || bus.push !== 8'h00) begin n_fail++; $display("FAIL uni_read: pop %h push %h want 02/00", bus.pop, bus.push); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if (bus.push !== 8'h04 || bus.pop !== 8'h00) begin n_fail++; $display("FAIL uni_write: push %h pop %h want 04/00", bus.push, bus.pop); end
        n_checks++;
        if (bus.D_push[2] !== 20'h02ABC) begin n_fail++; $display("FAIL uni_data: got %h want %h", bus.D_push[2], 20'h02ABC); end
        repeat (2) begin
            tick();
            n_checks++;
            if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL uni_idle: pop %h push %h want 00", bus.pop, bus.push); end
        end
    endtask

    task automatic test_broadcast();
        logic [DRV-1:0][PSZ-1:0] exp_lanes;
        logic [DRV-1:0]          exp_push;
        for (int i = 0; i < DRV; i++) exp_lanes[i] = 20'hFF123;
`ifdef BUS_BCAST_SELF_EN
        exp_push = 8'hFF;
`else
        exp_push = 8'hF7;
`endif
        bus.D_pop[3] = 20'hFF123;
        bus.pndng    = 8'h08;
        tick();
        n_checks++;
        if (bus.pop !== 8'h08) begin n_fail++; $display("FAIL bc_pop: got %h want %h", bus.pop, 8'h08); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if (bus.push !== exp_push) begin n_fail++; $display("FAIL bc_push: got %h want %h", bus.push, exp_push); end
        n_checks++;
        if (bus.D_push !== exp_lanes) begin n_fail++; $display("FAIL bc_lanes: got %h want %h", bus.D_push, exp_lanes); end
        tick();
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL bc_idle: pop %h push %h want 00", bus.pop, bus.push); end
    endtask

    task automatic test_round_robin();
        int             g;
        logic [PSZ-1:0] pkt;
        logic [DRV-1:0] exp_v;
        reset = 1'b0;
        tick();
        for (int i = 0; i < DRV; i++) bus.D_pop[i] = {8'((i + 1) % DRV), 4'hA, 8'(i)};
        bus.pndng = 8'hFF;
        reset     = 1'b1;
        for (int t = 0; t < 10; t++) begin
            g     = t % DRV;
            pkt   = {8'((g + 1) % DRV), 4'hA, 8'(g)};
            tick();
            exp_v = DRV'(1) << g;
            n_checks++;
            if (bus.pop !== exp_v || bus.push !== 8'h00) begin n_fail++; $display("FAIL rr_pop[%0d]: pop %h push %h want %h/00", t, bus.pop, bus.push, exp_v); end
            tick();
            exp_v = DRV'(1) << ((g + 1) % DRV);
            n_checks++;
            if (bus.push !== exp_v || bus.pop !== 8'h00) begin n_fail++; $display("FAIL rr_push[%0d]: push %h pop %h want %h/00", t, bus.push, bus.pop, exp_v); end
            n_checks++;
            if (bus.D_push[0] !== pkt) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", t, bus.D_push[0], pkt); end
            tick();
            n_checks++;
            if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL rr_idle[%0d]: pop %h push %h want 00", t, bus.pop, bus.push); end
        end
        bus.pndng = 8'h00;
        tick();
    endtask

    task automatic test_invalid_dest();
        bus.D_pop[5] = 20'h09000;
        bus.pndng    = 8'h20;
        tick();
        n_checks++;
        if (bus.pop !== 8'h20) begin n_fail++; $display("FAIL inv_pop: got %h want %h", bus.pop, 8'h20); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL inv_write: pop %h push %h want 00", bus.pop, bus.push); end
        tick();
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL inv_idle: pop %h push %h want 00", bus.pop, bus.push); end
        // A fresh request must be granted on the very next edge, proving the FSM is back in IDLE.
        bus.D_pop[5] = 20'h06111;
        bus.pndng    = 8'h20;
        tick();
        n_checks++;
        if (bus.pop !== 8'h20) begin n_fail++; $display("FAIL inv_regrant: got %h want %h", bus.pop, 8'h20); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if (bus.push !== 8'h40) begin n_fail++; $display("FAIL inv_recover_push: got %h want %h", bus.push, 8'h40); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.D_pop[0] = 20'h03AAA;
        bus.D_pop[7] = 20'h01777;
        bus.pndng    = 8'h81;
        tick();
        n_checks++;
        if (bus.pop !== 8'h80) begin n_fail++; $display("FAIL ar_pre_pop: got %h want %h", bus.pop, 8'h80); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL ar_strobes: pop %h push %h want 00", bus.pop, bus.push); end
        n_checks++;
        if (bus.D_push !== '0) begin n_fail++; $display("FAIL ar_dpush: got %h want 0", bus.D_push); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.pop !== 8'h01) begin n_fail++; $display("FAIL ar_first_grant: got %h want %h", bus.pop, 8'h01); end
        bus.pndng = 8'h80;
        tick();
        n_checks++;
        if (bus.push !== 8'h08) begin n_fail++; $display("FAIL ar_first_push: got %h want %h", bus.push, 8'h08); end
        tick();
        tick();
        n_checks++;
        if (bus.pop !== 8'h80) begin n_fail++; $display("FAIL ar_second_grant: got %h want %h", bus.pop, 8'h80); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if (bus.push !== 8'h02 || bus.D_push[1] !== 20'h01777) begin n_fail++; $display("FAIL ar_second_push: push %h data %h want 02/01777", bus.push, bus.D_push[1]); end
        tick();
    endtask

    task automatic test_self_unicast();
        bus.D_pop[4] = 20'h04055;
        bus.pndng    = 8'h10;
        tick();
        n_checks++;
        if (bus.pop !== 8'h10) begin n_fail++; $display("FAIL self_pop: got %h want %h", bus.pop, 8'h10); end
        bus.pndng = 8'h00;
        tick();
        n_checks++;
        if (bus.push !== 8'h10 || bus.pop !== 8'h00) begin n_fail++; $display("FAIL self_push: push %h pop %h want 10/00", bus.push, bus.pop); end
        n_checks++;
        if (bus.D_push[4] !== 20'h04055) begin n_fail++; $display("FAIL self_data: got %h want %h", bus.D_push[4], 20'h04055); end
        tick();
        n_checks++;
        if ((bus.pop | bus.push) !== 8'h00) begin n_fail++; $display("FAIL self_idle: pop %h push %h want 00", bus.pop, bus.push); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_round_robin();
        test_invalid_dest();
        test_async_reset();
        test_self_unicast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shared-bus generator and arbiter for `drvrs` agents.
- Each agent owns an external input FIFO that flags `pndng` when it holds a packet.
- The block selects one pending agent round-robin, pops one packet from it, decodes the 8-bit destination field, and pushes the packet into the destination agent's output FIFO, or into every other agent's FIFO on broadcast.
- It sits between the per-agent FIFOs as the only bus master.

Parameters:
- drvrs, 4, number of agents. Legal range 2..255.
- pckg_sz, 16, packet width in bits. Minimum 9.
- broadcast, 8'hFF, destination ID meaning "all agents". Must be >= drvrs.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- pndng, input, drvrs, bit i set = FIFO i holds a packet.
- D_pop, input, drvrs x pckg_sz (packed [drvrs-1:0][pckg_sz-1:0]), head word of FIFO i (first-word-fall-through).
- pop, output, drvrs, one-cycle pop strobe to FIFO i.
- push, output, drvrs, one-cycle push strobe to destination FIFO i.
- D_push, output, drvrs x pckg_sz, data presented to destination FIFOs. All lanes carry the same packet.

Behaviour:
- Packet format: [pckg_sz-1 : pckg_sz-8] = destination ID. Remaining low bits are payload and are passed unmodified.
- All outputs are registered.
- Reset (reset=0, asynchronous): pop=0, push=0, D_push=0, FSM=IDLE, last-grant pointer = drvrs-1, so the first grant goes to agent 0. Reset asserted mid-transfer aborts the transfer; a packet already popped is lost.
- FSM has three states, IDLE -> READ -> WRITE -> IDLE.
- IDLE:
  - If pndng != 0, select the first i with pndng[i]=1, searching from (ptr+1) mod drvrs upward with wrap.
  - Store the grant g and set ptr=g. Next state READ, with pop[g]=1 during READ.
  - If pndng == 0, stay in IDLE with all strobes 0.
- READ:
  - pop[g] is high for exactly this cycle; all other pop bits are 0.
  - On the closing edge, latch pkt=D_pop[g] and decode dest=pkt[pckg_sz-1 -: 8].
  - The grant is committed even if pndng[g] drops during READ.
  - Next state WRITE.
- WRITE:
  - D_push[every lane]=pkt for this cycle.
  - dest < drvrs: push[dest]=1 only. dest==g is allowed, so the packet loops back to its source.
  - dest == broadcast: push = all ones except bit g.
  - Otherwise (invalid ID): push=0 and the packet is silently dropped.
  - Next state IDLE.
- D_push holds its last value after WRITE; only push qualifies it.
- Throughput is one packet per 3 clocks. Latency is 1 cycle from grant in IDLE to pop, and 2 cycles from grant to push.
- Fairness: under continuous requests from all agents, the grant order is 0,1,…,drvrs-1,0,… and no agent waits more than drvrs transfers.
- pop and push are never asserted in the same cycle.

Optional Feature:
- Macro: BUS_BCAST_SELF_EN.
- Defined: a broadcast also pushes to the source agent, so push = all ones in WRITE.
- Undefined (default): a broadcast excludes the source, so bit g is 0.
- Unicast and invalid-ID behaviour is unaffected by the macro.

Test Plan (drvrs=8, pckg_sz=20, broadcast=8'hFF):
1. Unicast:
   - Stimulus: reset released; pndng=8'b0000_0010, D_pop[1]=20'h02_ABC.
   - Response: pop=8'h02 for 1 cycle; next cycle push=8'h04 and D_push[2]=20'h02ABC; then pop/push idle until new pndng.
2. Broadcast:
   - Stimulus: pndng[3]=1, D_pop[3]=20'hFF_123.
   - Response: pop=8'h08; then push=8'hF7 with all D_push lanes = 20'hFF123. With BUS_BCAST_SELF_EN defined, push=8'hFF.
3. Round-robin:
   - Stimulus: pndng=8'hFF held for 10 transfers; each D_pop[i] addressed to (i+1) mod 8.
   - Response: pop sequence 0,1,2,3,4,5,6,7,0,1; the push for each transfer equals 1<<((g+1) mod 8).
4. Invalid destination:
   - Stimulus: D_pop[5]=20'h09_000, pndng[5]=1.
   - Response: pop=8'h20 for 1 cycle; push stays 0 for the whole transfer; FSM returns to IDLE.
5. Async reset mid-transfer:
   - Stimulus: drop reset during READ, between clock edges.
   - Response: pop/push/D_push go to 0 immediately without waiting for a clock edge. After release with pndng=8'h81, the first grant is agent 0, then agent 7.
6. Self-addressed unicast:
   - Stimulus: D_pop[4]=20'h04_055.
   - Response: pop=8'h10, then push=8'h10 with D_push=20'h04055.
